// File: rtl/seven_seg_scan.sv
// Time-multiplexed N-digit seven-segment driver: latches a packed hex word and scans
// one digit at a time onto a shared segment bus, with leading-zero blanking and blink.
module seven_seg_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 25,
  parameter int HEX_EN     = 0,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic                    iEN,
  input  logic                    iLOAD,
  input  logic [4*NUM_DIGITS-1:0] iDATA,
  input  logic                    iBLANK_LZ,
  input  logic [NUM_DIGITS-1:0]   iBLINK_MASK,
  output logic [6:0]              oSEG7,
  output logic [NUM_DIGITS-1:0]   oDIG,
  output logic                    oFRAME
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FCNT_LAST  = FW'(BLINK_DIV - 1);

  localparam logic [6:0]            SEG_BLANK_N = 7'h7F;
  localparam logic [6:0]            SEG_OFF     = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF     = (ACTIVE_LOW != 0) ? '1 : '0;

  // Glyphs are kept in active-low form; polarity is applied once at the output.
  function automatic logic [6:0] glyph_n(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    if (HEX_EN == 0 && code > 4'h9) g = SEG_BLANK_N;
    return g;
  endfunction

  function automatic logic [6:0] seg_polarity(input logic [6:0] seg_n);
    return (ACTIVE_LOW != 0) ? seg_n : ~seg_n;
  endfunction

  function automatic logic [NUM_DIGITS-1:0] dig_polarity(input logic [NUM_DIGITS-1:0] onehot);
    return (ACTIVE_LOW != 0) ? ~onehot : onehot;
  endfunction

  logic [4*NUM_DIGITS-1:0] data_p0;
  logic [NUM_DIGITS-1:0]   mask_p0;
  logic [PW-1:0]           presc_p0;
  logic [IW-1:0]           idx_p0;
  logic [FW-1:0]           fcnt_p0;
  logic                    blink_ph_p0;

  logic [NUM_DIGITS-1:0]   upper_zero_p0;
  logic                    step_p0;
  logic                    wrap_p0;
  logic [6:0]              seg_p1;
  logic [NUM_DIGITS-1:0]   dig_p1;
  logic                    vld_p1;

  // ---- stage p0 -> p1: decode the currently selected digit ----
  always_comb begin
    logic       all_zero;
    logic [3:0] code;
    logic       blank;
    logic [NUM_DIGITS-1:0] onehot;
    all_zero      = 1'b1;
    code          = 4'h0;
    blank         = 1'b0;
    onehot        = '0;
    upper_zero_p0 = '0;
    // upper_zero_p0[k]: digit k and every more-significant digit are zero
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero         = all_zero && (data_p0[4*k +: 4] == 4'h0);
      upper_zero_p0[k] = all_zero;
    end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_p0 == IW'(k)) begin
        code      = data_p0[4*k +: 4];
        onehot[k] = 1'b1;
        blank     = (iBLANK_LZ && (k != 0) && upper_zero_p0[k]) ||
                    (mask_p0[k] && blink_ph_p0);
      end
    end
    seg_p1  = seg_polarity(blank ? SEG_BLANK_N : glyph_n(code));
    dig_p1  = dig_polarity(onehot);
    vld_p1  = iEN;
    step_p0 = (presc_p0 == PRESC_LAST);
    wrap_p0 = step_p0 && (idx_p0 == IDX_LAST);
  end

  // ---- stage p1: registered outputs and scan counters ----
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      data_p0     <= '0;
      mask_p0     <= '0;
      presc_p0    <= '0;
      idx_p0      <= '0;
      fcnt_p0     <= '0;
      blink_ph_p0 <= 1'b0;
      oSEG7       <= SEG_OFF;
      oDIG        <= DIG_OFF;
      oFRAME      <= 1'b0;
    end else begin
      if (iLOAD) begin
        data_p0 <= iDATA;
        mask_p0 <= iBLINK_MASK;
      end
      if (vld_p1) begin
        presc_p0 <= step_p0 ? '0 : presc_p0 + 1'b1;
        if (step_p0) idx_p0 <= wrap_p0 ? '0 : idx_p0 + 1'b1;
        if (wrap_p0) begin
          if (fcnt_p0 == FCNT_LAST) begin
            fcnt_p0     <= '0;
            blink_ph_p0 <= ~blink_ph_p0;
          end else begin
            fcnt_p0 <= fcnt_p0 + 1'b1;
          end
        end
        oSEG7  <= seg_p1;
        oDIG   <= dig_p1;
        oFRAME <= wrap_p0;
      end else begin
        // Blink phase deliberately holds across a disable.
        presc_p0 <= '0;
        idx_p0   <= '0;
        fcnt_p0  <= '0;
        oSEG7    <= SEG_OFF;
        oDIG     <= DIG_OFF;
        oFRAME   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: two instances (hex off/active-low, hex on/active-high) checked
// every cycle against a run-length model of the scan, plus directed reset checks.
module tb_seven_seg_scan;
  localparam int N     = 4;
  localparam int S     = 3;
  localparam int B     = 2;
  localparam int FRAME = N * S;

  logic            clk = 1'b0;
  logic            rst, en, load, lz;
  logic [4*N-1:0]  data;
  logic [N-1:0]    mask;
  logic [6:0]      seg0, seg1;
  logic [N-1:0]    dig0, dig1;
  logic            frm0, frm1;

  always #5 clk = ~clk;

  seven_seg_scan #(.NUM_DIGITS(N), .SCAN_DIV(S), .BLINK_DIV(B), .HEX_EN(0), .ACTIVE_LOW(1)) u_hex0 (
    .iCLK(clk), .iRST(rst), .iEN(en), .iLOAD(load), .iDATA(data), .iBLANK_LZ(lz),
    .iBLINK_MASK(mask), .oSEG7(seg0), .oDIG(dig0), .oFRAME(frm0));

  seven_seg_scan #(.NUM_DIGITS(N), .SCAN_DIV(S), .BLINK_DIV(B), .HEX_EN(1), .ACTIVE_LOW(0)) u_hex1 (
    .iCLK(clk), .iRST(rst), .iEN(en), .iLOAD(load), .iDATA(data), .iBLANK_LZ(lz),
    .iBLINK_MASK(mask), .oSEG7(seg1), .oDIG(dig1), .oFRAME(frm1));

  int checks = 0;
  int errors = 0;

  // Reference model state: enabled cycles in the current run, blink phase at run start.
  int          run  = 0;
  logic        base = 1'b0;
  logic [15:0] m_data = '0;
  logic [N-1:0] m_mask = '0;
  logic [6:0]  e_seg0, e_seg1;
  logic [N-1:0] e_dig0, e_dig1;
  logic        e_frm;

  logic [6:0] gl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    int d, code, frames;
    logic ph, blank;
    @(posedge clk);
    if (rst) begin
      e_seg0 = 7'h7F; e_dig0 = '1; e_seg1 = 7'h00; e_dig1 = '0; e_frm = 1'b0;
      run = 0; base = 1'b0; m_data = '0; m_mask = '0;
    end else begin
      frames = run / FRAME;
      if (en) begin
        d     = (run / S) % N;
        code  = (m_data >> (4 * d)) & 15;
        ph    = base ^ logic'((frames / B) % 2);
        blank = (lz && d > 0 && (m_data >> (4 * d)) == 0) || (m_mask[d] && ph);
        e_seg0 = (blank || code >= 10) ? 7'h7F : gl[code];
        e_seg1 = blank ? 7'h00 : ~gl[code];
        e_dig1 = '0;
        e_dig1[d] = 1'b1;
        e_dig0 = ~e_dig1;
        e_frm  = (run % FRAME) == FRAME - 1;
        run++;
      end else begin
        e_seg0 = 7'h7F; e_dig0 = '1; e_seg1 = 7'h00; e_dig1 = '0; e_frm = 1'b0;
        base = base ^ logic'((frames / B) % 2);
        run  = 0;
      end
      if (load) begin
        m_data = data;
        m_mask = mask;
      end
    end
    #1;
    check("seg_hex0", 16'(seg0), 16'(e_seg0));
    check("dig_hex0", 16'(dig0), 16'(e_dig0));
    check("frame_hex0", 16'(frm0), 16'(e_frm));
    check("seg_hex1", 16'(seg1), 16'(e_seg1));
    check("dig_hex1", 16'(dig1), 16'(e_dig1));
    check("frame_hex1", 16'(frm1), 16'(e_frm));
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [N-1:0] m);
    data = d; mask = m; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; load = 1'b0; lz = 1'b0; data = '0; mask = '0;
    // Reset held two cycles
    tick();
    tick();
    check("reset_seg", 16'(seg0), 16'h007F);
    check("reset_dig", 16'(dig0), 16'h000F);
    check("reset_frame", 16'(frm0), 16'h0000);
    rst = 1'b0;
    tick();
    check("first_digit", 16'(dig0), 16'h000E);
    check("first_glyph", 16'(seg0), 16'h0040);
    run_cycles(30);

    do_load(16'h1234, 4'b0000);
    run_cycles(14);

    lz = 1'b1;
    do_load(16'h0070, 4'b0000);
    run_cycles(14);
    do_load(16'h0000, 4'b0000);
    run_cycles(14);
    lz = 1'b0;

    do_load(16'hA0F0, 4'b0000);
    run_cycles(14);

    do_load(16'h1234, 4'b0001);
    run_cycles(5 * FRAME);

    // Reset mid-scan, then disable mid-digit
    run_cycles(7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run_cycles(16);
    do_load(16'h5678, 4'b1010);
    run_cycles(4);
    en = 1'b0;
    run_cycles(2);
    en = 1'b1;
    run_cycles(3 * FRAME);

    for (int i = 0; i < 2500; i++) begin
      en   = ($urandom_range(0, 99) != 0);
      load = ($urandom_range(0, 15) == 0);
      data = 16'($urandom);
      if ($urandom_range(0, 3) == 0) data = data & 16'h00FF;
      mask = N'($urandom);
      if ($urandom_range(0, 31) == 0) lz = ~lz;
      rst  = ($urandom_range(0, 499) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
